mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while an instruction request waits; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request, held high until i_ack is seen.
REQ-005 SHALL have port i_addr  input  16  instruction-fetch word address.
REQ-006 SHALL have port i_ack  output  1  one-cycle instruction completion pulse.
REQ-007 SHALL have port i_rdata  output  16  fetched word, registered.
REQ-008 SHALL have port d_req  input  1  data request, held high until d_ack is seen.
REQ-009 SHALL have port d_we  input  1  data request is a write when 1.
REQ-010 SHALL have port d_addr  input  16  data word address.
REQ-011 SHALL have port d_wdata  input  16  data write word.
REQ-012 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port d_rdata  output  16  data read word, registered.
REQ-014 SHALL have port m_addr  output  16  shared single-port memory address.
REQ-015 SHALL have port m_we  output  1  shared memory write enable.
REQ-016 SHALL have port m_wdata  output  16  shared memory write data.
REQ-017 SHALL have port m_rdata  input  16  shared memory read data, valid one cycle after m_addr is presented.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, ACCESS, RESP; transitions IDLE->ACCESS (any request), ACCESS->RESP (always), RESP->IDLE (always).
REQ-020 SHALL, in IDLE with at least one request, select a winner and latch its address, write flag and write data on that edge.
REQ-021 SHALL grant the data port when only d_req is high, and the instruction port when only i_req is high.
REQ-022 SHALL, with both requests high, grant the data port unless the starvation counter equals STARVE_LIMIT, in which case it grants the instruction port.
REQ-023 SHALL increment the starvation counter on a data grant made while i_req is high, and clear it on any instruction grant or on a data grant made while i_req is low.
REQ-024 SHALL, in ACCESS, drive m_addr and m_wdata from the latch and assert m_we for exactly that cycle when the latched request is a write.
REQ-025 SHALL hold m_we low in IDLE and RESP; m_addr and m_wdata hold their last latched values outside ACCESS.
REQ-026 SHALL, in RESP, pulse the winner's ack for exactly one cycle; the other ack stays low.
REQ-027 SHALL, for a granted read, capture m_rdata into the winner's rdata register on the ACCESS->RESP edge; rdata is valid while ack is high and held until that port's next read.
REQ-028 SHALL leave d_rdata unchanged on a write.
REQ-029 SHALL give a fixed latency of 2 cycles from the grant edge to ack, and one access per 3 cycles.
REQ-030 SHALL ignore changes to address, data or write flag after the grant edge; a request dropped after grant still completes and is acked.
REQ-031 SHALL treat a request still high in the IDLE cycle after its ack as a new request.

Reset
REQ-032 SHALL, while rst_n is low, force state IDLE, i_ack=0, d_ack=0, m_we=0, busy=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, starvation counter=0.
REQ-033 SHALL abort any in-flight access on reset, with m_we dropping immediately and no ack issued.
REQ-034 SHALL take its first grant on the first rising clk edge after rst_n rises when a request is present.

Verification
REQ-035 SHALL cover: instruction read of 0x0010 with memory holding 0xBEEF there -> i_ack 2 cycles after grant, i_rdata=0xBEEF, m_we never high.
REQ-036 SHALL cover: data write 0x1234 to 0x0200 -> m_we high for exactly the ACCESS cycle with m_addr=0x0200, m_wdata=0x1234; d_ack in RESP; d_rdata unchanged.
REQ-037 SHALL cover: both requests held continuously with STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating.
REQ-038 SHALL cover: d_addr changed from 0x0004 to 0x0008 the cycle after grant -> memory accessed at 0x0004.
REQ-039 SHALL cover: rst_n pulsed low during ACCESS of a write -> m_we low immediately, no d_ack, all outputs 0.
REQ-040 SHALL cover: i_req deasserted one cycle after grant -> i_ack still pulses once; then IDLE with busy=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory.
// States: IDLE = waiting for a request | ACCESS = memory cycle | RESP = ack pulse to the winner.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [15:0] m_addr,
  output logic        m_we,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        we_q, we_d;
  logic        win_i_q, win_i_d;
  logic [3:0]  starve_q, starve_d;
  logic        grant_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      win_i_q   <= 1'b0;
      starve_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      win_i_q   <= win_i_d;
      starve_q  <= starve_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Data wins ties until the fetch has been passed over STARVE_LIMIT times in a row.
  assign grant_i = !d_req || (i_req && (starve_q == LIMIT));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    win_i_d   = win_i_q;
    starve_d  = starve_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ACCESS;
          win_i_d = grant_i;
          if (grant_i) begin
            addr_d   = i_addr;
            we_d     = 1'b0;
            starve_d = '0;
          end else begin
            addr_d   = d_addr;
            we_d     = d_we;
            wdata_d  = d_wdata;
            starve_d = i_req ? (starve_q + 4'd1) : 4'd0;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) begin
          if (win_i_q) i_rdata_d = m_rdata;
          else         d_rdata_d = m_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // m_we is decoded from state so an async reset drops it without waiting for a clock.
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_we    = (state_q == ACCESS) && we_q;
  assign i_ack   = (state_q == RESP) && win_i_q;
  assign d_ack   = (state_q == RESP) && !win_i_q;
  assign busy    = (state_q != IDLE);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, m_we, busy;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  logic        bd_we;
  logic [15:0] bd_addr, bd_data;
  logic [15:0] mem_aa [logic [15:0]];
  logic [15:0] ref_aa [logic [15:0]];

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_aa.exists(a) ? ref_aa[a] : pat(a);
  endfunction

  function automatic logic [15:0] rnd_addr();
    return 16'h8000 | 16'($urandom_range(0, 15));
  endfunction

  // Memory: writes on the rising edge, read data settles on the falling edge of the address cycle.
  always @(posedge clk) begin
    if (m_we)  mem_aa[m_addr] = m_wdata;
    if (bd_we) mem_aa[bd_addr] = bd_data;
  end
  always @(negedge clk) m_rdata <= mem_aa.exists(m_addr) ? mem_aa[m_addr] : pat(m_addr);

  task automatic mem_poke(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for the ack of one port, dropping its request on the ack cycle.
  task automatic wait_ack(input bit inst, output int lat, output int we_cnt,
                          output logic [15:0] we_addr, output logic [15:0] we_data, output bit other);
    lat = -1; we_cnt = 0; other = 0; we_addr = '0; we_data = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (m_we) begin we_cnt++; we_addr = m_addr; we_data = m_wdata; end
      if (inst ? d_ack : i_ack) other = 1;
      if (inst ? i_ack : d_ack) begin
        lat = n;
        if (inst) i_req = 0; else d_req = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({i_ack, d_ack, m_we, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b, expected 0000", {i_ack, d_ack, m_we, busy}); end
    n_checks++; if ({m_addr, m_wdata} !== 32'h0) begin n_fail++; $display("FAIL reset_mbus: got %h, expected 0", {m_addr, m_wdata}); end
    n_checks++; if ({i_rdata, d_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 0", {i_rdata, d_rdata}); end
    i_req = 1; i_addr = 16'h0030;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy: got %b, expected 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || m_addr !== 16'h0030) begin n_fail++; $display("FAIL first_grant: got busy=%b addr=%h, expected 1/0030", busy, m_addr); end
    @(negedge clk);
    n_checks++; if (i_ack !== 1'b1 || i_rdata !== pat(16'h0030)) begin n_fail++; $display("FAIL first_ack: got ack=%b rdata=%h, expected 1/%h", i_ack, i_rdata, pat(16'h0030)); end
    i_req = 0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || i_ack !== 1'b0) begin n_fail++; $display("FAIL first_idle: got busy=%b ack=%b, expected 0/0", busy, i_ack); end
  endtask

  task automatic test_inst_read();
    int lat, wec; logic [15:0] wa, wd; bit oth;
    mem_poke(16'h0010, 16'hBEEF);
    i_req = 1; i_addr = 16'h0010;
    wait_ack(1, lat, wec, wa, wd, oth);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL iread_latency: got %0d, expected 2", lat); end
    n_checks++; if (wec !== 0 || oth !== 1'b0) begin n_fail++; $display("FAIL iread_side: got we_cycles=%0d d_ack=%b, expected 0/0", wec, oth); end
    n_checks++; if (i_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL iread_data: got %h, expected beef", i_rdata); end
    @(negedge clk);
    n_checks++; if (i_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL iread_idle: got ack=%b busy=%b, expected 0/0", i_ack, busy); end
  endtask

  task automatic test_data_write();
    int lat, wec; logic [15:0] wa, wd; bit oth;
    do_reset();
    d_req = 1; d_we = 0; d_addr = 16'h0300;
    wait_ack(0, lat, wec, wa, wd, oth);
    n_checks++; if (d_rdata !== pat(16'h0300)) begin n_fail++; $display("FAIL dread_data: got %h, expected %h", d_rdata, pat(16'h0300)); end
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    wait_ack(0, lat, wec, wa, wd, oth);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL dwrite_latency: got %0d, expected 2", lat); end
    n_checks++; if (wec !== 1 || wa !== 16'h0200 || wd !== 16'h1234) begin n_fail++; $display("FAIL dwrite_bus: got cycles=%0d addr=%h data=%h, expected 1/0200/1234", wec, wa, wd); end
    n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL dwrite_iack: got %b, expected 0", oth); end
    n_checks++; if (d_rdata !== pat(16'h0300)) begin n_fail++; $display("FAIL dwrite_rdata_kept: got %h, expected %h", d_rdata, pat(16'h0300)); end
    d_we = 0;
    @(negedge clk);
    n_checks++; if (m_we !== 1'b0 || m_addr !== 16'h0200 || m_wdata !== 16'h1234) begin n_fail++; $display("FAIL dwrite_hold: got we=%b addr=%h data=%h, expected 0/0200/1234", m_we, m_addr, m_wdata); end
    d_req = 1; d_addr = 16'h0200;
    wait_ack(0, lat, wec, wa, wd, oth);
    n_checks++; if (d_rdata !== 16'h1234) begin n_fail++; $display("FAIL dwrite_readback: got %h, expected 1234", d_rdata); end
    @(negedge clk);
  endtask

  task automatic test_addr_change();
    mem_poke(16'h0004, 16'h1111);
    mem_poke(16'h0008, 16'h2222);
    d_req = 1; d_we = 0; d_addr = 16'h0004;
    @(negedge clk);
    d_addr = 16'h0008; d_we = 1; d_wdata = 16'hDEAD;
    #1;
    n_checks++; if (m_addr !== 16'h0004 || m_we !== 1'b0) begin n_fail++; $display("FAIL addrchg_bus: got addr=%h we=%b, expected 0004/0", m_addr, m_we); end
    @(negedge clk);
    n_checks++; if (d_ack !== 1'b1 || d_rdata !== 16'h1111) begin n_fail++; $display("FAIL addrchg_data: got ack=%b rdata=%h, expected 1/1111", d_ack, d_rdata); end
    d_req = 0; d_we = 0;
    @(negedge clk);
    d_req = 1; d_addr = 16'h0008;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (d_ack !== 1'b1 || d_rdata !== 16'h2222) begin n_fail++; $display("FAIL addrchg_other: got ack=%b rdata=%h, expected 1/2222", d_ack, d_rdata); end
    d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    i_req = 1; i_addr = 16'h0020;
    @(negedge clk);
    i_req = 0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %b, expected 1", busy); end
    @(negedge clk);
    n_checks++; if (i_ack !== 1'b1 || i_rdata !== pat(16'h0020)) begin n_fail++; $display("FAIL drop_ack: got ack=%b rdata=%h, expected 1/%h", i_ack, i_rdata, pat(16'h0020)); end
    @(negedge clk);
    n_checks++; if (i_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got ack=%b busy=%b, expected 0/0", i_ack, busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_stay_idle: got %b, expected 0", busy); end
  endtask

  task automatic test_starvation();
    bit exp_pat [10];
    int acks;
    exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    acks = 0;
    do_reset();
    i_addr = 16'h0100; d_addr = 16'h0180; d_we = 0; i_req = 1; d_req = 1;
    for (int n = 0; n < 60 && acks < 10; n++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        n_checks++;
        if (i_ack !== exp_pat[acks] || d_ack !== !exp_pat[acks]) begin
          n_fail++; $display("FAIL starve_grant%0d: got i_ack=%b d_ack=%b, expected instr=%b", acks, i_ack, d_ack, exp_pat[acks]);
        end
        acks++;
        if (acks == 10) begin i_req = 0; d_req = 0; end
      end
    end
    n_checks++; if (acks !== 10) begin n_fail++; $display("FAIL starve_count: got %0d acks, expected 10", acks); end
    i_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_during_access();
    bit seen;
    do_reset();
    d_req = 1; d_we = 0; d_addr = 16'h0050;
    @(negedge clk);
    @(negedge clk);
    d_req = 0;
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'h7777;
    @(negedge clk);
    n_checks++; if (m_we !== 1'b1) begin n_fail++; $display("FAIL rstacc_pre_we: got %b, expected 1", m_we); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({m_we, busy, i_ack, d_ack} !== 4'b0) begin n_fail++; $display("FAIL rstacc_ctrl: got %b, expected 0000", {m_we, busy, i_ack, d_ack}); end
    n_checks++; if ({m_addr, m_wdata, i_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL rstacc_data: got %h, expected 0", {m_addr, m_wdata, i_rdata, d_rdata}); end
    d_req = 0; d_we = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) seen = 1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (d_ack) seen = 1;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstacc_no_ack: got d_ack seen=%b, expected 0", seen); end
    d_req = 1; d_addr = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (d_ack !== 1'b1 || d_rdata !== pat(16'h0040)) begin n_fail++; $display("FAIL rstacc_aborted_write: got ack=%b rdata=%h, expected 1/%h", d_ack, d_rdata, pat(16'h0040)); end
    d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int k, run;
    bit win_i, t_we, ifl_i, ifl_d;
    logic [15:0] t_addr, t_wdata, exp_ir, exp_dr;
    do_reset();
    k = 0; run = 0; win_i = 0; t_we = 0; t_addr = '0; t_wdata = '0; exp_ir = '0; exp_dr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_checks++; if (busy !== (k != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b, expected %b", cyc, busy, k != 0); end
      n_checks++; if (m_we !== (k == 1 && t_we)) begin n_fail++; $display("FAIL rnd_we c%0d: got %b, expected %b", cyc, m_we, k == 1 && t_we); end
      if (k == 1) begin
        n_checks++; if (m_addr !== t_addr) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h, expected %h", cyc, m_addr, t_addr); end
        if (t_we) begin
          n_checks++; if (m_wdata !== t_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h, expected %h", cyc, m_wdata, t_wdata); end
        end
      end
      n_checks++; if (i_ack !== (k == 2 && win_i)) begin n_fail++; $display("FAIL rnd_iack c%0d: got %b, expected %b", cyc, i_ack, k == 2 && win_i); end
      n_checks++; if (d_ack !== (k == 2 && !win_i)) begin n_fail++; $display("FAIL rnd_dack c%0d: got %b, expected %b", cyc, d_ack, k == 2 && !win_i); end
      n_checks++; if (i_rdata !== exp_ir) begin n_fail++; $display("FAIL rnd_irdata c%0d: got %h, expected %h", cyc, i_rdata, exp_ir); end
      n_checks++; if (d_rdata !== exp_dr) begin n_fail++; $display("FAIL rnd_drdata c%0d: got %h, expected %h", cyc, d_rdata, exp_dr); end

      ifl_i = (k != 0) && win_i;
      ifl_d = (k != 0) && !win_i;
      if (k == 2 && win_i) begin
        i_req = 1'($urandom_range(0, 1)); i_addr = rnd_addr();
      end else if (ifl_i) begin
        i_addr = rnd_addr();
        if ($urandom_range(0, 3) == 0) i_req = 0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = rnd_addr();
      end
      if (k == 2 && !win_i) begin
        d_req = 1'($urandom_range(0, 1)); d_addr = rnd_addr();
        d_we = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
      end else if (ifl_d) begin
        d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
        if ($urandom_range(0, 3) == 0) d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = rnd_addr();
        d_we = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
      end

      case (k)
        0: if (i_req || d_req) begin
             win_i = !d_req || (i_req && run == STARVE_LIMIT);
             if (win_i) begin
               run = 0; t_addr = i_addr; t_we = 0;
             end else begin
               run = i_req ? run + 1 : 0;
               t_addr = d_addr; t_we = d_we; t_wdata = d_wdata;
             end
             k = 1;
           end
        1: begin
             if (t_we)       ref_aa[t_addr] = t_wdata;
             else if (win_i) exp_ir = ref_rd(t_addr);
             else            exp_dr = ref_rd(t_addr);
             k = 2;
           end
        default: k = 0;
      endcase
    end
    i_req = 0; d_req = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bd_we = 0; bd_addr = '0; bd_data = '0;
    test_reset();
    test_inst_read();
    test_data_write();
    test_addr_change();
    test_req_drop();
    test_starvation();
    test_reset_during_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
